// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op sequencer: expands a register mask into one register/address micro-op per cycle.
// Optional macro LMSM_R7_GUARD_EN strips R7 (PC) from the mask and reports it on r7_dropped.
module lm_sm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [MASK_W-1:0] imm_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              stall_req,
  output logic              uop_valid,
  output logic              uop_store,
  output logic [2:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              r7_dropped
);

  typedef enum logic {IDLE, RUN} seqState_t;

  seqState_t         state, stateNext;
  logic [MASK_W-1:0] remMask, remMaskNext;
  logic [ADDR_W-1:0] baseReg, baseRegNext;
  logic [ADDR_W-1:0] offset, offsetNext;
  logic              uopValidNext, uopStoreNext, uopLastNext, r7DroppedNext;
  logic [2:0]        uopRegNext;
  logic [ADDR_W-1:0] uopAddrNext;

  logic [MASK_W-1:0] effMask, effRest, remRest;
  logic              accept, r7Requested;

  function automatic logic [2:0] lowestIndex(input logic [MASK_W-1:0] m);
    lowestIndex = '0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (m[i]) lowestIndex = 3'(i);
  endfunction

`ifdef LMSM_R7_GUARD_EN
  assign effMask     = imm_mask & ~(MASK_W'(1) << (MASK_W - 1));
  assign r7Requested = imm_mask[MASK_W-1];
`else
  assign effMask     = imm_mask;
  assign r7Requested = 1'b0;
`endif

  // Clearing the lowest set bit: x & (x-1)
  assign effRest = effMask & (effMask - MASK_W'(1));
  assign remRest = remMask & (remMask - MASK_W'(1));
  assign accept  = (state == IDLE) && start && !flush && !hold;

  assign busy      = (state == RUN);
  assign stall_req = (accept && (effRest != '0)) || ((state == RUN) && !uop_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remMask    <= '0;
      baseReg    <= '0;
      offset     <= '0;
      uop_valid  <= 1'b0;
      uop_store  <= 1'b0;
      uop_reg    <= '0;
      uop_addr   <= '0;
      uop_last   <= 1'b0;
      r7_dropped <= 1'b0;
    end else begin
      state      <= stateNext;
      remMask    <= remMaskNext;
      baseReg    <= baseRegNext;
      offset     <= offsetNext;
      uop_valid  <= uopValidNext;
      uop_store  <= uopStoreNext;
      uop_reg    <= uopRegNext;
      uop_addr   <= uopAddrNext;
      uop_last   <= uopLastNext;
      r7_dropped <= r7DroppedNext;
    end
  end

  always_comb begin
    stateNext     = state;
    remMaskNext   = remMask;
    baseRegNext   = baseReg;
    offsetNext    = offset;
    uopValidNext  = uop_valid;
    uopStoreNext  = uop_store;
    uopRegNext    = uop_reg;
    uopAddrNext   = uop_addr;
    uopLastNext   = uop_last;
    r7DroppedNext = r7_dropped;

    case (state)
      IDLE: begin
        if (flush) begin
          r7DroppedNext = 1'b0;
        end else if (accept) begin
          r7DroppedNext = r7Requested;
          if (effMask != '0) begin
            // The first micro-op is produced directly from the incoming mask
            stateNext    = RUN;
            baseRegNext  = base_addr;
            uopValidNext = 1'b1;
            uopStoreNext = is_store;
            uopRegNext   = lowestIndex(effMask);
            uopAddrNext  = base_addr;
            remMaskNext  = effRest;
            offsetNext   = ADDR_W'(1);
            uopLastNext  = (effRest == '0);
          end
        end
      end
      RUN: begin
        if (flush) begin
          stateNext     = IDLE;
          uopValidNext  = 1'b0;
          uopLastNext   = 1'b0;
          remMaskNext   = '0;
          offsetNext    = '0;
          r7DroppedNext = 1'b0;
        end else if (!hold) begin
          if (uop_last) begin
            stateNext    = IDLE;
            uopValidNext = 1'b0;
            uopLastNext  = 1'b0;
            offsetNext   = '0;
          end else begin
            uopRegNext  = lowestIndex(remMask);
            uopAddrNext = baseReg + offset;
            remMaskNext = remRest;
            offsetNext  = offset + ADDR_W'(1);
            uopLastNext = (remRest == '0);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Randomized plus directed bench for lm_sm_sequencer against a queue-based micro-op model.
module tb_lm_sm_sequencer;
  localparam int ADDR_W = 16;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, is_store, hold, flush;
  logic [MASK_W-1:0] imm_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, stall_req, uop_valid, uop_store, uop_last, r7_dropped;
  logic [2:0]        uop_reg;
  logic [ADDR_W-1:0] uop_addr;

  lm_sm_sequencer #(.ADDR_W(ADDR_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .imm_mask(imm_mask), .base_addr(base_addr), .hold(hold), .flush(flush),
    .busy(busy), .stall_req(stall_req), .uop_valid(uop_valid), .uop_store(uop_store),
    .uop_reg(uop_reg), .uop_addr(uop_addr), .uop_last(uop_last), .r7_dropped(r7_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        r;
    logic [ADDR_W-1:0] a;
    logic              s;
  } uop_t;

  uop_t pending[$];
  uop_t cur;
  bit   showing;
  bit   expR7;
  int   totalChecks = 0;
  int   badChecks = 0;

`ifdef LMSM_R7_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int honouredBits(input logic [MASK_W-1:0] m);
    int n = 0;
    for (int i = 0; i < MASK_W; i++)
      if (m[i] && !(GUARD && i == MASK_W - 1)) n++;
    return n;
  endfunction

  task automatic buildList(input logic [MASK_W-1:0] m, input logic [ADDR_W-1:0] b, input logic s);
    int k = 0;
    uop_t u;
    pending.delete();
    for (int i = 0; i < MASK_W; i++) begin
      if (m[i] && !(GUARD && i == MASK_W - 1)) begin
        u.r = 3'(i);
        u.a = b + ADDR_W'(k);
        u.s = s;
        pending.push_back(u);
        k++;
      end
    end
  endtask

  task automatic checkAll(input string ctx);
    bit stallExp;
    stallExp = (!showing && start && !flush && !hold && honouredBits(imm_mask) > 1) ||
               (showing && pending.size() > 0);
    checkOutput({ctx, ".busy"},      32'(busy),       32'(showing));
    checkOutput({ctx, ".uop_valid"}, 32'(uop_valid),  32'(showing));
    checkOutput({ctx, ".uop_last"},  32'(uop_last),   32'(showing && pending.size() == 0));
    checkOutput({ctx, ".stall_req"}, 32'(stall_req),  32'(stallExp));
    checkOutput({ctx, ".r7_dropped"},32'(r7_dropped), 32'(expR7));
    if (showing) begin
      checkOutput({ctx, ".uop_reg"},   32'(uop_reg),   32'(cur.r));
      checkOutput({ctx, ".uop_addr"},  32'(uop_addr),  32'(cur.a));
      checkOutput({ctx, ".uop_store"}, 32'(uop_store), 32'(cur.s));
    end
  endtask

  task automatic modelStep();
    if (flush) begin
      pending.delete();
      showing = 1'b0;
      expR7   = 1'b0;
    end else if (!showing) begin
      if (start && !hold) begin
        expR7 = GUARD && imm_mask[MASK_W-1];
        buildList(imm_mask, base_addr, is_store);
        if (pending.size() > 0) begin
          cur     = pending.pop_front();
          showing = 1'b1;
        end
      end
    end else if (!hold) begin
      if (pending.size() == 0) showing = 1'b0;
      else cur = pending.pop_front();
    end
  endtask

  task automatic applyStimulus(input string ctx, input bit st, input bit sto,
                               input logic [MASK_W-1:0] m, input logic [ADDR_W-1:0] b,
                               input bit h, input bit f);
    @(negedge clk);
    start = st; is_store = sto; imm_mask = m; base_addr = b; hold = h; flush = f;
    #1 checkAll(ctx);
    @(posedge clk);
    modelStep();
  endtask

  task automatic idleCycles(input string ctx, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ctx, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkResetOutputs(input string ctx);
    checkOutput({ctx, ".busy"},       32'(busy),       32'h0);
    checkOutput({ctx, ".uop_valid"},  32'(uop_valid),  32'h0);
    checkOutput({ctx, ".uop_last"},   32'(uop_last),   32'h0);
    checkOutput({ctx, ".uop_store"},  32'(uop_store),  32'h0);
    checkOutput({ctx, ".uop_reg"},    32'(uop_reg),    32'h0);
    checkOutput({ctx, ".uop_addr"},   32'(uop_addr),   32'h0);
    checkOutput({ctx, ".r7_dropped"}, 32'(r7_dropped), 32'h0);
    checkOutput({ctx, ".stall_req"},  32'(stall_req),  32'h0);
  endtask

  initial begin
    reset = 1'b0; start = 0; is_store = 0; imm_mask = '0; base_addr = '0; hold = 0; flush = 0;
    showing = 0; expR7 = 0;
    repeat (2) @(negedge clk);
    #1 checkResetOutputs("por");
    @(negedge clk) reset = 1'b1;

    $display("[TB] directed: LM mask 0x05");
    applyStimulus("lm05", 1, 0, 8'h05, 16'h0100, 0, 0);
    idleCycles("lm05", 3);

    $display("[TB] directed: SM mask 0xFF with wrap");
    applyStimulus("smFF", 1, 1, 8'hFF, 16'hFFFE, 0, 0);
    idleCycles("smFF", 9);

    $display("[TB] directed: hold during first micro-op");
    applyStimulus("hold12", 1, 0, 8'h12, 16'h0040, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("hold12", 0, 0, '0, '0, 1, 0);
    idleCycles("hold12", 3);

    $display("[TB] directed: flush on second micro-op");
    applyStimulus("flushF0", 1, 1, 8'hF0, 16'h1000, 0, 0);
    idleCycles("flushF0", 1);
    applyStimulus("flushF0", 0, 0, '0, '0, 0, 1);
    applyStimulus("flushF0", 1, 0, 8'h03, 16'h2000, 0, 0);
    idleCycles("flushF0", 3);

    $display("[TB] directed: empty mask, then async reset mid-sequence");
    applyStimulus("zero", 1, 0, 8'h00, 16'h3000, 0, 0);
    idleCycles("zero", 2);
    applyStimulus("arst", 1, 1, 8'h0F, 16'h4000, 0, 0);
    idleCycles("arst", 1);
    @(negedge clk);
    start = 0; imm_mask = '0; hold = 0; flush = 0;
    #2 reset = 1'b0;
    #1 checkResetOutputs("arst");
    pending.delete(); showing = 0; expR7 = 0;
    @(negedge clk) reset = 1'b1;

    $display("[TB] directed: mask 0x81");
    applyStimulus("m81", 1, 0, 8'h81, 16'h0020, 0, 0);
    idleCycles("m81", 3);

    $display("[TB] random stimulus");
    for (int c = 0; c < 600; c++) begin
      logic [MASK_W-1:0] m;
      logic [ADDR_W-1:0] b;
      m = ($urandom % 8 == 0) ? '0 : MASK_W'($urandom);
      b = ($urandom % 4 == 0) ? ADDR_W'(16'hFFF8 + ($urandom % 8)) : ADDR_W'($urandom);
      applyStimulus("rnd", ($urandom % 3 == 0), 1'($urandom), m, b,
                    ($urandom % 5 == 0), ($urandom % 20 == 0));
    end
    idleCycles("tail", 10);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
